burst_read_bridge: RTL and testbench

// - Adapts a DMA-side burst read port (rd/addr/wait_n/valid/burstDone) to an Avalon-MM burst read master on the DDR.
// - Sits directly upstream of the burst read DMA. Issues one fixed-length burst per accepted request.
// - Forwards returned beats through a 1-cycle register and flags the last beat with burst_done.

---
 rtl/burst_read_bridge.sv | 117 +++++++++++
 tb/tb_burst_read_bridge.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/burst_read_bridge.sv
// Purpose: turns one DMA burst request into one fixed-length Avalon-MM burst read and forwards the returned beats.
// Latency: the request passes straight through in IDLE; each DDR beat reaches dma_dout/dma_valid 1 cycle later.
// Backpressure: dma_wait_n mirrors ~ddr_wait_req in IDLE and is 0 while a burst is open; BURST_TIMEOUT_EN adds a data watchdog.
module burst_read_bridge #(
    parameter int          BURST_LEN   = 16,
    parameter logic [31:0] ADDR_OFFSET = 32'h0,
    parameter int          TIMEOUT     = 255
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        dma_rd,
    input  logic [31:0] dma_addr,
    output logic        dma_wait_n,
    output logic        dma_valid,
    output logic [63:0] dma_dout,
    output logic        dma_burst_done,
    output logic        ddr_rd,
    output logic [31:0] ddr_addr,
    output logic [7:0]  ddr_burst_count,
    input  logic        ddr_wait_req,
    input  logic        ddr_valid,
    input  logic [63:0] ddr_dout,
    output logic        timeout_err
);

    if (BURST_LEN < 2 || BURST_LEN > 255) begin : g_bad_burst_len
        $error("burst_read_bridge: BURST_LEN must be within 2..255");
    end
    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("burst_read_bridge: TIMEOUT must be within 1..255");
    end

    typedef enum logic {
        IDLE = 1'b0,
        DATA = 1'b1
    } state_t;

    localparam logic [7:0] LAST_BEAT = 8'(BURST_LEN - 1);

    state_t     state;
    logic [7:0] beat_cnt;
    logic       accept;

    // Only one burst may be open, so the command side is gated by the state.
    assign ddr_rd          = (state == IDLE) & dma_rd;
    assign ddr_addr        = dma_addr + ADDR_OFFSET;
    assign ddr_burst_count = 8'(BURST_LEN);
    assign dma_wait_n      = (state == IDLE) & ~ddr_wait_req;
    assign accept          = ddr_rd & ~ddr_wait_req;

`ifdef BURST_TIMEOUT_EN
    localparam logic [7:0] WD_LAST = 8'(TIMEOUT - 1);
    logic [7:0] wd_cnt;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            beat_cnt       <= '0;
            dma_valid      <= 1'b0;
            dma_dout       <= '0;
            dma_burst_done <= 1'b0;
`ifdef BURST_TIMEOUT_EN
            wd_cnt         <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            dma_valid      <= 1'b0;
            dma_burst_done <= 1'b0;
            case (state)
                IDLE: begin
                    // Beats showing up here belong to an abandoned burst and are dropped.
                    if (accept) begin
                        state    <= DATA;
                        beat_cnt <= '0;
`ifdef BURST_TIMEOUT_EN
                        wd_cnt   <= '0;
`endif
                    end
                end
                DATA: begin
                    if (ddr_valid) begin
                        dma_valid <= 1'b1;
                        dma_dout  <= ddr_dout;
`ifdef BURST_TIMEOUT_EN
                        wd_cnt    <= '0;
`endif
                        if (beat_cnt == LAST_BEAT) begin
                            dma_burst_done <= 1'b1;
                            beat_cnt       <= '0;
                            state          <= IDLE;
                        end else begin
                            beat_cnt <= beat_cnt + 8'd1;
                        end
                    end
`ifdef BURST_TIMEOUT_EN
                    // The TIMEOUT-th silent cycle closes the burst without data.
                    else if (wd_cnt == WD_LAST) begin
                        dma_burst_done <= 1'b1;
                        timeout_err    <= 1'b1;
                        wd_cnt         <= '0;
                        state          <= IDLE;
                    end else begin
                        wd_cnt <= wd_cnt + 8'd1;
                    end
`endif
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef BURST_TIMEOUT_EN
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_burst_read_bridge.sv
// Directed bench for burst_read_bridge with a transaction-level reference model checked every cycle.
module tb_burst_read_bridge;
    localparam int          BL  = 16;
    localparam logic [31:0] OFF = 32'h1000;
    localparam int          TO  = 20;

    logic        clock = 1'b0;
    logic        reset;
    logic        dma_rd;
    logic [31:0] dma_addr;
    logic        dma_wait_n, dma_valid, dma_burst_done, ddr_rd, timeout_err;
    logic [63:0] dma_dout;
    logic [31:0] ddr_addr;
    logic [7:0]  ddr_burst_count;
    logic        ddr_wait_req, ddr_valid;
    logic [63:0] ddr_dout;

    burst_read_bridge #(.BURST_LEN(BL), .ADDR_OFFSET(OFF), .TIMEOUT(TO)) dut (
        .clock(clock), .reset(reset),
        .dma_rd(dma_rd), .dma_addr(dma_addr), .dma_wait_n(dma_wait_n),
        .dma_valid(dma_valid), .dma_dout(dma_dout), .dma_burst_done(dma_burst_done),
        .ddr_rd(ddr_rd), .ddr_addr(ddr_addr), .ddr_burst_count(ddr_burst_count),
        .ddr_wait_req(ddr_wait_req), .ddr_valid(ddr_valid), .ddr_dout(ddr_dout),
        .timeout_err(timeout_err)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Reference model: burst open/closed plus beats still owed.
    int          cyc = 0;
    bit          busy = 0;
    int          remaining = 0;
    int          silent = 0;
    bit          m_valid = 0, m_done = 0, m_err = 0;
    logic [63:0] m_dout = '0;

    always @(posedge clock) begin
        cyc++;
        if (reset) begin
            busy = 0; remaining = 0; silent = 0;
            m_valid = 0; m_done = 0; m_err = 0; m_dout = '0;
        end else begin
            m_valid = 0;
            m_done  = 0;
            if (!busy) begin
                if (dma_rd && !ddr_wait_req) begin
                    busy = 1; remaining = BL; silent = 0;
                end
            end else if (ddr_valid) begin
                m_valid = 1; m_dout = ddr_dout; silent = 0;
                remaining--;
                if (remaining == 0) begin
                    m_done = 1; busy = 0;
                end
            end
`ifdef BURST_TIMEOUT_EN
            else begin
                silent++;
                if (silent == TO) begin
                    m_done = 1; m_err = 1; busy = 0;
                end
            end
`endif
        end
    end

    int          valid_cnt = 0, done_cnt = 0;
    int          last_valid_cyc = 0, done_cyc = 0;
    logic        done_had_valid = 0;
    logic [63:0] rx_q[$];
    logic [63:0] sent_q[$];

    always @(negedge clock) begin
        if (cyc >= 1) begin
            check("dma_valid", 64'(dma_valid), 64'(m_valid));
            check("dma_burst_done", 64'(dma_burst_done), 64'(m_done));
            check("dma_dout", dma_dout, m_dout);
            check("timeout_err", 64'(timeout_err), 64'(m_err));
            check("ddr_rd", 64'(ddr_rd), 64'(!busy && dma_rd));
            check("dma_wait_n", 64'(dma_wait_n), 64'(!busy && !ddr_wait_req));
            if (!busy && dma_rd) begin
                check("ddr_addr", 64'(ddr_addr), 64'(dma_addr + OFF));
                check("ddr_burst_count", 64'(ddr_burst_count), 64'(BL));
            end
            if (dma_valid) begin
                valid_cnt++;
                last_valid_cyc = cyc;
                rx_q.push_back(dma_dout);
            end
            if (dma_burst_done) begin
                done_cnt++;
                done_cyc = cyc;
                done_had_valid = dma_valid;
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_stats();
        valid_cnt = 0;
        done_cnt  = 0;
        rx_q.delete();
        sent_q.delete();
    endtask

    task automatic send_beats(input int n, input bit gapped, input logic [63:0] base);
        for (int i = 0; i < n; i++) begin
            ddr_valid = 1'b0;
            if (gapped) repeat ($urandom_range(0, 3)) tick();
            ddr_valid = 1'b1;
            ddr_dout  = base + 64'(i);
            sent_q.push_back(ddr_dout);
            tick();
        end
        ddr_valid = 1'b0;
    endtask

    task automatic request(input logic [31:0] addr);
        dma_rd   = 1'b1;
        dma_addr = addr;
        tick();
        dma_rd   = 1'b0;
    endtask

    initial begin
        reset = 1'b1; dma_rd = 1'b0; dma_addr = '0;
        ddr_wait_req = 1'b0; ddr_valid = 1'b0; ddr_dout = '0;
        repeat (2) tick();
        reset = 1'b0;

        // Reset state
        @(negedge clock);
        check("rst_dma_valid", 64'(dma_valid), 64'd0);
        check("rst_dma_dout", dma_dout, 64'd0);
        check("rst_burst_done", 64'(dma_burst_done), 64'd0);
        check("rst_timeout_err", 64'(timeout_err), 64'd0);
        check("rst_wait_n", 64'(dma_wait_n), 64'd1);
        tick();

        // Single burst
        clear_stats();
        dma_rd = 1'b1; dma_addr = 32'h80;
        @(negedge clock);
        check("s1_ddr_rd", 64'(ddr_rd), 64'd1);
        check("s1_ddr_addr", 64'(ddr_addr), 64'h1080);
        check("s1_burst_count", 64'(ddr_burst_count), 64'd16);
        tick();
        dma_rd = 1'b0;
        send_beats(BL, 1'b0, 64'hA000_0000_0000_0000);
        repeat (3) tick();
        check("s1_valid_count", 64'(valid_cnt), 64'd16);
        check("s1_done_count", 64'(done_cnt), 64'd1);
        check("s1_last_dout", dma_dout, 64'hA000_0000_0000_000F);

        // Wait-request stall
        clear_stats();
        ddr_wait_req = 1'b1; dma_rd = 1'b1; dma_addr = 32'h200;
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("s2_stall_wait_n", 64'(dma_wait_n), 64'd0);
            check("s2_stall_ddr_rd", 64'(ddr_rd), 64'd1);
            check("s2_stall_addr", 64'(ddr_addr), 64'h1200);
            tick();
        end
        ddr_wait_req = 1'b0;
        @(negedge clock);
        check("s2_accept_wait_n", 64'(dma_wait_n), 64'd1);
        tick();
        dma_rd = 1'b0;
        @(negedge clock);
        check("s2_busy_wait_n", 64'(dma_wait_n), 64'd0);
        tick();
        send_beats(BL, 1'b0, 64'hB000_0000_0000_0000);
        repeat (2) tick();
        check("s2_done_count", 64'(done_cnt), 64'd1);

        // Gapped data
        clear_stats();
        request(32'h300);
        send_beats(BL, 1'b1, 64'hC0DE_0000_0000_0100);
        repeat (2) tick();
        check("s3_valid_count", 64'(valid_cnt), 64'd16);
        check("s3_done_count", 64'(done_cnt), 64'd1);
        check("s3_rx_size", 64'(rx_q.size()), 64'(sent_q.size()));
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++)
            check("s3_rx_order", rx_q[i], sent_q[i]);

        // Back-to-back bursts
        clear_stats();
        request(32'h80);
        send_beats(BL, 1'b0, 64'hD000_0000_0000_0000);
        dma_rd = 1'b1; dma_addr = 32'h100;
        @(negedge clock);
        check("s4_done_now", 64'(dma_burst_done), 64'd1);
        check("s4_valid_now", 64'(dma_valid), 64'd1);
        check("s4_ddr_rd", 64'(ddr_rd), 64'd1);
        check("s4_ddr_addr", 64'(ddr_addr), 64'h1100);
        tick();
        dma_rd = 1'b0;
        send_beats(BL, 1'b0, 64'hD100_0000_0000_0000);
        repeat (2) tick();
        check("s4_valid_count", 64'(valid_cnt), 64'd32);
        check("s4_done_count", 64'(done_cnt), 64'd2);

        // Reset mid-burst, stale beats dropped
        request(32'h400);
        send_beats(7, 1'b0, 64'hE000_0000_0000_0000);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_stats();
        send_beats(9, 1'b0, 64'hEE00_0000_0000_0000);
        repeat (2) tick();
        check("s5_stale_valid", 64'(valid_cnt), 64'd0);
        check("s5_stale_done", 64'(done_cnt), 64'd0);
        @(negedge clock);
        check("s5_idle_wait_n", 64'(dma_wait_n), 64'd1);
        tick();
        clear_stats();
        dma_rd = 1'b1; dma_addr = 32'h80;
        @(negedge clock);
        check("s5_ddr_addr", 64'(ddr_addr), 64'h1080);
        tick();
        dma_rd = 1'b0;
        send_beats(BL, 1'b0, 64'hF000_0000_0000_0000);
        repeat (2) tick();
        check("s5_valid_count", 64'(valid_cnt), 64'd16);
        check("s5_done_count", 64'(done_cnt), 64'd1);

`ifdef BURST_TIMEOUT_EN
        // Watchdog: 3 beats then silence
        clear_stats();
        request(32'h500);
        send_beats(3, 1'b0, 64'h7000_0000_0000_0000);
        repeat (25) tick();
        check("s6_valid_count", 64'(valid_cnt), 64'd3);
        check("s6_done_count", 64'(done_cnt), 64'd1);
        check("s6_done_delay", 64'(done_cyc - last_valid_cyc), 64'd20);
        check("s6_done_no_valid", 64'(done_had_valid), 64'd0);
        check("s6_err_set", 64'(timeout_err), 64'd1);
        clear_stats();
        request(32'h80);
        send_beats(BL, 1'b0, 64'h7100_0000_0000_0000);
        repeat (2) tick();
        check("s6_after_done", 64'(done_cnt), 64'd1);
        check("s6_err_sticky", 64'(timeout_err), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clock);
        check("s6_err_cleared", 64'(timeout_err), 64'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
